// File: rtl/spmv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spmv_mem_arbiter
// Description : Shares the single DCP memory request/response port between
//               the dense-vector prefetcher (port 0) and the CISR sparse-
//               matrix streamer (port 1). Requests are arbitrated round-robin
//               combinationally and tagged with the lowest free transaction
//               ID. An owner/tag table per ID routes each response back to
//               the issuing requester one cycle after it arrives.
// Ports       : clk, rst_n (sync, active-low)
//               i_req{0,1}_val/_addr/_tag, o_req{0,1}_rdy : requester side
//               o_mem_req_val/_transid/_addr, i_mem_req_rdy : memory request
//               i_mem_resp_val/_transid/_data               : memory response
//               o_resp{0,1}_val, o_resp_tag, o_resp_data    : routed response
//               o_inflight  : number of busy transaction IDs
//               o_err_unexp : one-cycle pulse on an unexpected response
// Revision    : 1.0 - initial release
// ============================================================================
module spmv_mem_arbiter #(
    parameter int NUM_TIDS = 8,
    parameter int TAG_W    = 4,
    parameter int ADDR_W   = 40,
    parameter int DATA_W   = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0: dense-vector prefetcher
    input  logic              i_req0_val,
    output logic              o_req0_rdy,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [TAG_W-1:0]  i_req0_tag,
    // requester 1: sparse-matrix streamer
    input  logic              i_req1_val,
    output logic              o_req1_rdy,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [TAG_W-1:0]  i_req1_tag,
    // memory request
    output logic              o_mem_req_val,
    input  logic              i_mem_req_rdy,
    output logic [5:0]        o_mem_req_transid,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    // memory response
    input  logic              i_mem_resp_val,
    input  logic [5:0]        i_mem_resp_transid,
    input  logic [DATA_W-1:0] i_mem_resp_data,
    // routed response
    output logic              o_resp0_val,
    output logic              o_resp1_val,
    output logic [TAG_W-1:0]  o_resp_tag,
    output logic [DATA_W-1:0] o_resp_data,
    // status
    output logic [6:0]        o_inflight,
    output logic              o_err_unexp
);

    localparam int IDX_W = (NUM_TIDS > 1) ? $clog2(NUM_TIDS) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_TIDS-1:0] r_busy;
    logic [NUM_TIDS-1:0] r_owner;               // 0 = port 0, 1 = port 1
    logic [TAG_W-1:0]    r_tag [NUM_TIDS];
    logic                r_last_grant;          // port granted most recently
    logic                r_resp0_val;
    logic                r_resp1_val;
    logic [TAG_W-1:0]    r_resp_tag;
    logic [DATA_W-1:0]   r_resp_data;
    logic [6:0]          r_inflight;
    logic                r_err_unexp;

    // ------------------------------------------------------------------
    // Request path (combinational)
    // ------------------------------------------------------------------
    logic             w_free_any;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_winner;
    logic             w_grant;

    assign w_free_any = ~(&r_busy);

    // Lowest-index free ID: scan from the top so the lowest match wins.
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_TIDS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // On contention the port that was not granted last wins; otherwise the
    // sole valid port wins.
    always_comb begin
        w_winner = 1'b0;
        if (i_req0_val && i_req1_val) begin
            w_winner = ~r_last_grant;
        end else if (i_req1_val) begin
            w_winner = 1'b1;
        end
    end

    // mem_req_val deliberately excludes i_mem_req_rdy (valid/ready rule).
    assign o_mem_req_val     = (i_req0_val | i_req1_val) & w_free_any;
    assign w_grant           = o_mem_req_val & i_mem_req_rdy;
    assign o_req0_rdy        = w_grant & ~w_winner;
    assign o_req1_rdy        = w_grant &  w_winner;
    assign o_mem_req_addr    = w_winner ? i_req1_addr : i_req0_addr;
    assign o_mem_req_transid = 6'(w_free_idx);

    // ------------------------------------------------------------------
    // Response lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_resp_idx;
    logic             w_resp_in_range;
    logic             w_resp_hit;

    assign w_resp_idx      = i_mem_resp_transid[IDX_W-1:0];
    // 7-bit compare so NUM_TIDS = 64 does not wrap to zero.
    assign w_resp_in_range = ({1'b0, i_mem_resp_transid} < 7'(NUM_TIDS));
    assign w_resp_hit      = i_mem_resp_val & w_resp_in_range & r_busy[w_resp_idx];

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // A granted ID is always free and a hit ID is always busy, so the set
    // and clear below can never target the same bit in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_owner      <= '0;
            for (int i = 0; i < NUM_TIDS; i++) begin
                r_tag[i] <= '0;
            end
            r_last_grant <= 1'b1;               // port 0 wins first contention
            r_resp0_val  <= 1'b0;
            r_resp1_val  <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
            r_inflight   <= '0;
            r_err_unexp  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_busy[w_free_idx]  <= 1'b1;
                r_owner[w_free_idx] <= w_winner;
                r_tag[w_free_idx]   <= w_winner ? i_req1_tag : i_req0_tag;
                r_last_grant        <= w_winner;
            end
            if (w_resp_hit) begin
                r_busy[w_resp_idx] <= 1'b0;
                r_resp_tag         <= r_tag[w_resp_idx];
                r_resp_data        <= i_mem_resp_data;
            end
            r_resp0_val <= w_resp_hit & ~r_owner[w_resp_idx];
            r_resp1_val <= w_resp_hit &  r_owner[w_resp_idx];
            r_err_unexp <= i_mem_resp_val & ~w_resp_hit;
            // Tracks popcount(busy); grant and free in one cycle cancel out.
            r_inflight  <= r_inflight + 7'(w_grant) - 7'(w_resp_hit);
        end
    end

    assign o_resp0_val = r_resp0_val;
    assign o_resp1_val = r_resp1_val;
    assign o_resp_tag  = r_resp_tag;
    assign o_resp_data = r_resp_data;
    assign o_inflight  = r_inflight;
    assign o_err_unexp = r_err_unexp;

endmodule
`default_nettype wire

// File: tb/tb_spmv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spmv_mem_arbiter
// Description : Directed bench for spmv_mem_arbiter. Request-side outputs are
//               checked inline against hand-computed values; every response
//               driven into the memory side pushes its expected routed result
//               into a queue that an independent monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spmv_mem_arbiter;

    localparam int NUM_TIDS = 8;
    localparam int TAG_W    = 4;
    localparam int ADDR_W   = 40;
    localparam int DATA_W   = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_val, req1_val, req0_rdy, req1_rdy;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [TAG_W-1:0]  req0_tag, req1_tag;
    logic              mem_req_val, mem_req_rdy;
    logic [5:0]        mem_req_transid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_val;
    logic [5:0]        mem_resp_transid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              resp0_val, resp1_val, err_unexp;
    logic [TAG_W-1:0]  resp_tag;
    logic [DATA_W-1:0] resp_data;
    logic [6:0]        inflight;

    always #5 clk = ~clk;

    spmv_mem_arbiter #(
        .NUM_TIDS(NUM_TIDS), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req0_val         (req0_val),
        .o_req0_rdy         (req0_rdy),
        .i_req0_addr        (req0_addr),
        .i_req0_tag         (req0_tag),
        .i_req1_val         (req1_val),
        .o_req1_rdy         (req1_rdy),
        .i_req1_addr        (req1_addr),
        .i_req1_tag         (req1_tag),
        .o_mem_req_val      (mem_req_val),
        .i_mem_req_rdy      (mem_req_rdy),
        .o_mem_req_transid  (mem_req_transid),
        .o_mem_req_addr     (mem_req_addr),
        .i_mem_resp_val     (mem_resp_val),
        .i_mem_resp_transid (mem_resp_transid),
        .i_mem_resp_data    (mem_resp_data),
        .o_resp0_val        (resp0_val),
        .o_resp1_val        (resp1_val),
        .o_resp_tag         (resp_tag),
        .o_resp_data        (resp_data),
        .o_inflight         (inflight),
        .o_err_unexp        (err_unexp)
    );

    typedef struct packed {
        logic              err;
        logic              r0;
        logic              r1;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int seed);
        logic [31:0] w;
        w = 32'(seed) * 32'h9E37_79B9 + 32'h1234_5678;
        return {16{w}};
    endfunction

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_val = 0; req1_val = 0; req0_addr = '0; req1_addr = '0;
        req0_tag = '0; req1_tag = '0; mem_req_rdy = 1;
        mem_resp_val = 0; mem_resp_transid = '0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    // Single-port request with hand-computed expected transid.
    task automatic issue(input bit port, input logic [ADDR_W-1:0] addr,
                         input logic [TAG_W-1:0] tag, input int exp_tid);
        if (port) begin req1_val = 1; req1_addr = addr; req1_tag = tag; end
        else      begin req0_val = 1; req0_addr = addr; req0_tag = tag; end
        mem_req_rdy = 1;
        #1;
        chk("issue_val",    64'(mem_req_val), 64'd1);
        chk("issue_tid",    64'(mem_req_transid), 64'(exp_tid));
        chk("issue_addr",   64'(mem_req_addr), 64'(addr));
        chk("issue_rdy",    {62'd0, req1_rdy, req0_rdy}, port ? 64'd2 : 64'd1);
        tick();
        req0_val = 0; req1_val = 0;
    endtask

    // Drive one response; expectation goes to the scoreboard.
    task automatic respond(input int tid, input int seed, input bit is_err,
                           input bit port, input logic [TAG_W-1:0] tag);
        exp_t e;
        mem_resp_val = 1;
        mem_resp_transid = 6'(tid);
        mem_resp_data = mk_data(seed);
        e.err  = is_err;
        e.r0   = !is_err && !port;
        e.r1   = !is_err && port;
        e.tag  = tag;
        e.data = mk_data(seed);
        exp_q.push_back(e);
        tick();
        mem_resp_val = 0; mem_resp_data = '0;
    endtask

    // Monitor: samples registered outputs on the falling edge.
    always @(negedge clk) begin
        if (resp0_val || resp1_val || err_unexp) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexp_output: got r0=%0b r1=%0b err=%0b tag=%0h, required none",
                         resp0_val, resp1_val, err_unexp, resp_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({err_unexp, resp0_val, resp1_val} !== {e.err, e.r0, e.r1} ||
                    (!e.err && (resp_tag !== e.tag || resp_data !== e.data))) begin
                    n_errors++;
                    $display("FAIL resp_route: got err=%0b r0=%0b r1=%0b tag=%0h data[63:0]=%0h, required err=%0b r0=%0b r1=%0b tag=%0h data[63:0]=%0h",
                             err_unexp, resp0_val, resp1_val, resp_tag, resp_data[63:0],
                             e.err, e.r0, e.r1, e.tag, e.data[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state
        #1;
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_memval",   64'(mem_req_val), 64'd0);
        chk("rst_resp",     {61'd0, resp0_val, resp1_val, err_unexp}, 64'd0);
        chk("rst_tag",      64'(resp_tag), 64'd0);
        chk("rst_data",     resp_data[63:0], 64'd0);

        // Single request / response
        issue(0, 40'h1000, 4'd3, 0);
        chk("single_inflight1", 64'(inflight), 64'd1);
        respond(0, 1, 0, 0, 4'd3);
        chk("single_inflight0", 64'(inflight), 64'd0);

        // Contention: grants alternate 0,1,0,1 with tids 0..3
        do_reset();
        req0_val = 1; req0_addr = 40'h2000; req0_tag = 4'hA;
        req1_val = 1; req1_addr = 40'h3000; req1_tag = 4'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_rdy",  {62'd0, req1_rdy, req0_rdy}, (i % 2) ? 64'd2 : 64'd1);
            chk("cont_tid",  64'(mem_req_transid), 64'(i));
            chk("cont_addr", 64'(mem_req_addr), (i % 2) ? 64'h3000 : 64'h2000);
            tick();
        end
        chk("cont_inflight4", 64'(inflight), 64'd4);
        // Grant (port 0, tid 4) and free of tid 0 in the same cycle
        mem_resp_val = 1; mem_resp_transid = 6'd0; mem_resp_data = mk_data(10);
        exp_q.push_back('{err: 1'b0, r0: 1'b1, r1: 1'b0, tag: 4'hA, data: mk_data(10)});
        #1;
        chk("cont_sim_rdy", {62'd0, req1_rdy, req0_rdy}, 64'd1);
        chk("cont_sim_tid", 64'(mem_req_transid), 64'd4);
        tick();
        mem_resp_val = 0; req0_val = 0; req1_val = 0;
        chk("cont_sim_inflight", 64'(inflight), 64'd4);
        respond(1, 11, 0, 1, 4'hB);
        respond(2, 12, 0, 0, 4'hA);
        respond(3, 13, 0, 1, 4'hB);
        respond(4, 14, 0, 0, 4'hA);
        chk("cont_inflight0", 64'(inflight), 64'd0);

        // Full pool
        do_reset();
        for (int i = 0; i < NUM_TIDS; i++) begin
            issue(0, 40'h4000 + 40'(i * 64), 4'(i), i);
        end
        chk("full_inflight", 64'(inflight), 64'd8);
        req0_val = 1; req0_addr = 40'h5000; req0_tag = 4'h1;
        req1_val = 1; req1_addr = 40'h6000; req1_tag = 4'h2;
        #1;
        chk("full_memval", 64'(mem_req_val), 64'd0);
        chk("full_rdy",    {62'd0, req1_rdy, req0_rdy}, 64'd0);
        // Freeing tid 5 must not make it allocatable in the same cycle
        mem_resp_val = 1; mem_resp_transid = 6'd5; mem_resp_data = mk_data(20);
        exp_q.push_back('{err: 1'b0, r0: 1'b1, r1: 1'b0, tag: 4'd5, data: mk_data(20)});
        #1;
        chk("full_free_same", 64'(mem_req_val), 64'd0);
        tick();
        mem_resp_val = 0;
        #1;
        chk("full_after_val", 64'(mem_req_val), 64'd1);
        chk("full_after_tid", 64'(mem_req_transid), 64'd5);
        chk("full_after_rdy", {62'd0, req1_rdy, req0_rdy}, 64'd2);
        chk("full_after_inflight", 64'(inflight), 64'd7);
        tick();
        req0_val = 0; req1_val = 0;
        chk("full_refill_inflight", 64'(inflight), 64'd8);

        // Backpressure
        do_reset();
        mem_req_rdy = 0;
        req1_val = 1; req1_addr = 40'h7000; req1_tag = 4'hC;
        #1;
        chk("bp_val", 64'(mem_req_val), 64'd1);
        chk("bp_rdy", {62'd0, req1_rdy, req0_rdy}, 64'd0);
        tick();
        chk("bp_noalloc", 64'(inflight), 64'd0);
        mem_req_rdy = 1;
        #1;
        chk("bp_tid", 64'(mem_req_transid), 64'd0);
        chk("bp_grant", {62'd0, req1_rdy, req0_rdy}, 64'd2);
        tick();
        req1_val = 0;
        chk("bp_inflight", 64'(inflight), 64'd1);
        respond(0, 30, 0, 1, 4'hC);

        // Out-of-order responses
        do_reset();
        issue(0, 40'h8000, 4'd7, 0);
        issue(1, 40'h8040, 4'd8, 1);
        issue(0, 40'h8080, 4'd9, 2);
        respond(2, 40, 0, 0, 4'd9);
        respond(0, 41, 0, 0, 4'd7);
        respond(1, 42, 0, 1, 4'd8);
        chk("ooo_inflight", 64'(inflight), 64'd0);

        // Unexpected responses and reset mid-operation
        do_reset();
        respond(12, 50, 1, 0, '0);
        respond(3, 51, 1, 0, '0);
        chk("err_nochange", 64'(inflight), 64'd0);
        issue(0, 40'h9000, 4'd1, 0);
        issue(1, 40'h9040, 4'd2, 1);
        issue(0, 40'h9080, 4'd3, 2);
        chk("pre_rst_inflight", 64'(inflight), 64'd3);
        do_reset();
        respond(1, 52, 1, 0, '0);
        chk("post_rst_inflight", 64'(inflight), 64'd0);

        tick();
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
- Shares the single DCP memory request/response port of the SpMV accelerator between two requesters: port 0 is the dense-vector prefetcher and port 1 is the CISR sparse-matrix streamer (value, column index and row length).
- Allocates transaction IDs from a bounded pool and records an owner table for each ID.
- Routes each L2 response back to the requester that issued it, together with that requester's local tag.
- Sits between the SpMV control FSM / loaders and the tile's DCP NoC interface.

Parameters:
- NUM_TIDS, 8: in-flight transaction IDs, power of 2, at most 64; transid range is 0..NUM_TIDS-1.
- TAG_W, 4: width of the requester-local tag.
- ADDR_W, 40: physical address width (DCP_PADDR).
- DATA_W, 512: response data width (DCP_NOC_RES_DATA_SIZE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req0_val  in  1  vector prefetcher request valid.
- req0_rdy  out  1  request 0 accepted this cycle.
- req0_addr  in  ADDR_W  request 0 physical address.
- req0_tag  in  TAG_W  request 0 local tag.
- req1_val  in  1  matrix streamer request valid.
- req1_rdy  out  1  request 1 accepted this cycle.
- req1_addr  in  ADDR_W  request 1 physical address.
- req1_tag  in  TAG_W  request 1 local tag.
- mem_req_val  out  1  request to memory hierarchy.
- mem_req_rdy  in  1  network accepts request.
- mem_req_transid  out  6  allocated transaction ID, zero-extended.
- mem_req_addr  out  ADDR_W  forwarded address.
- mem_resp_val  in  1  memory response valid.
- mem_resp_transid  in  6  response transaction ID.
- mem_resp_data  in  DATA_W  response line.
- resp0_val  out  1  response for requester 0.
- resp1_val  out  1  response for requester 1.
- resp_tag  out  TAG_W  local tag of the routed response.
- resp_data  out  DATA_W  routed response data, shared by both requesters.
- inflight  out  7  number of busy transaction IDs.
- err_unexp  out  1  one-cycle pulse on an unexpected response.

Behaviour:
- Reset (rst_n=0 at posedge):
  - busy bitmap, owner table and tag table cleared.
  - Round-robin pointer set so that port 0 has priority.
  - resp0_val=0, resp1_val=0, resp_tag=0, resp_data=0, err_unexp=0, inflight=0.
  - mem_req_val=0, because no requester is valid during reset; the request path is combinational.
- Request path (combinational, zero latency):
  - can_issue = mem_req_rdy AND at least one free ID.
  - If only one reqN_val is high, it wins. If both are high, the winner is the port that was not granted last (round-robin); the pointer updates only on a grant.
  - mem_req_val = (req0_val OR req1_val) AND at least one free ID. It must not depend on mem_req_rdy.
  - mem_req_addr and transid come from the winner. The transid is the lowest-index free ID.
  - reqN_rdy = winner==N AND can_issue. At most one rdy is high per cycle.
  - Requesters hold val/addr/tag stable until rdy. The arbiter may switch winner while unstalled.
- Allocation (at the posedge of a grant):
  - busy[id]=1, owner[id]=N, tag[id]=reqN_tag.
- Response path (one-cycle registered latency):
  - On mem_resp_val with transid < NUM_TIDS and busy[transid]=1: the next cycle drives resp{owner}_val=1 with resp_tag=tag[transid] and resp_data=mem_resp_data. busy[transid] clears at the same edge.
  - Requesters must always accept responses; there is no response backpressure.
  - Unexpected response (transid >= NUM_TIDS, or the ID is not busy): dropped, err_unexp=1 for one cycle, no state change.
- Simultaneous events:
  - A grant and a response free in the same cycle are both applied.
  - A freed ID becomes allocatable the following cycle, never the same cycle.
  - inflight = popcount(busy) and is registered. When a grant and a free coincide it is unchanged.
- Full: all IDs busy means mem_req_val=0 and both rdy=0 until a response frees an ID.
- Reset mid-operation: all tables clear. Responses to pre-reset IDs arrive with the ID not busy, so they raise err_unexp and are dropped.
- Width:
  - transid is zero-extended from log2(NUM_TIDS) to 6 bits.
  - inflight holds the range 0..NUM_TIDS.

Test Plan:
- Single request: req0_val=1, addr=0x1000, tag=3, mem_req_rdy=1 -> same cycle mem_req_val=1, transid=0, addr=0x1000, req0_rdy=1. Response transid=0, data=D -> next cycle resp0_val=1, resp_tag=3, resp_data=D, inflight back to 0.
- Contention: both val high continuously, rdy=1, responses returned promptly -> grants alternate 0,1,0,1 and transids 0..3 are used in order. Check that no port is starved.
- Full pool: 8 grants with no responses -> inflight=8, mem_req_val=0, both rdy=0. Return transid=5 -> next cycle resp valid. The following request gets transid 5.
- Backpressure: mem_req_rdy=0 with req1_val=1 -> mem_req_val=1, req1_rdy=0, no allocation. Raise rdy -> grant occurs and transid=0.
- Out-of-order: issue tids 0,1,2 (ports 0,1,0, tags 7,8,9). Respond in order 2,0,1 -> resp0 tag 9, then resp0 tag 7, then resp1 tag 8.
- Errors and reset: response transid=12 -> err_unexp pulse with no resp. Reset with 3 in flight, then response transid=1 -> err_unexp, inflight=0.
